// File: rtl/buzzer_pkg.sv
// buzzer_pkg: shared definitions for the buzzer melody sequencer.
//   state_t      sequencer state encoding (IDLE, LOAD, PLAY, GAP)
//   TUNE_REST    tune code that plays silence
//   TUNE_MIN/MAX valid audible tune code range
//   *_MSB/*_LSB  field positions inside a 16-bit note entry {tune, beats}
package buzzer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_PLAY = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   localparam logic [7:0] TUNE_REST = 8'h00;
   localparam logic [7:0] TUNE_MIN  = 8'h11;
   localparam logic [7:0] TUNE_MAX  = 8'h37;

   localparam int unsigned TUNE_MSB = 15;
   localparam int unsigned TUNE_LSB = 8;
   localparam int unsigned DUR_MSB  = 7;
   localparam int unsigned DUR_LSB  = 0;

   function automatic logic tune_in_range(input logic [7:0] t);
      return (t >= TUNE_MIN) && (t <= TUNE_MAX);
   endfunction

   function automatic logic is_audible(input logic [7:0] t);
      return t != TUNE_REST;
   endfunction

endpackage

// File: rtl/buzzer_note_fifo.sv
// buzzer_note_fifo: DEPTH x WIDTH synchronous show-ahead FIFO for note entries.
//   clk, rst   clock, synchronous active-high reset (empties the FIFO)
//   push       write push_data (accepted when not full, or when full with a pop in the same cycle)
//   push_data  entry to write
//   pop        remove the head entry (ignored when empty)
//   head       current head entry, valid while empty=0
//   full/empty occupancy flags
//   level      number of stored entries
// The caller decides whether a push against a full FIFO is legal; the FIFO
// itself accepts push+pop when full so an entry can be recirculated in place.
module buzzer_note_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign level   = count;
   assign head    = mem[rd_ptr];
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/buzzer_sequencer.sv
// buzzer_sequencer: melody sequencer between the bus-side buzzer registers
// and the tune_decoder / tune_pwm pair.
//   clk, rst   clock, synchronous active-high reset
//   wr_en      push wr_data into the note FIFO (dropped when full)
//   wr_data    [15:8] tune code (8'h00 = rest), [7:0] duration in beats
//   start      begin playback (sampled in IDLE only)
//   stop       abort playback from any state
//   tune       tune code to tune_decoder
//   pwm_en     enable to tune_pwm
//   busy       1 whenever the sequencer is not IDLE
//   done       one-cycle pulse when the FIFO drains naturally
//   full       note FIFO full
//   level      note FIFO occupancy
//   overflow   sticky dropped-write flag, cleared by start or rst
//   loop_mode  recirculate each played entry (present only with BUZZER_LOOP_EN)
// Build option: define BUZZER_LOOP_EN to add loop_mode and melody looping.
module buzzer_sequencer
   import buzzer_pkg::*;
#(
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned BEAT_DIV   = 6_250_000,
   parameter int unsigned GAP_CYCLES = 500_000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [15:0]              wr_data,
   input  logic                     start,
   input  logic                     stop,
   output logic [7:0]               tune,
   output logic                     pwm_en,
   output logic                     busy,
   output logic                     done,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow
`ifdef BUZZER_LOOP_EN
   ,input logic                     loop_mode
`endif
);

   localparam int unsigned LW        = $clog2(DEPTH) + 1;
   localparam logic [23:0] BEAT_LAST = 24'(BEAT_DIV - 1);
   localparam logic [23:0] GAP_LAST  = (GAP_CYCLES == 0) ? 24'd0 : 24'(GAP_CYCLES - 1);

   state_t       state_q;
   state_t       state_d;
   logic         finish_d;

   logic [7:0]   tune_lat;
   logic [7:0]   dur_lat;
   logic [23:0]  pre_cnt;
   logic [7:0]   beat_cnt;
   logic [23:0]  gap_cnt;

   logic [15:0]  fifo_head;
   logic         fifo_empty;
   logic [LW-1:0] fifo_level;
   logic         fifo_push;
   logic         fifo_pop;
   logic [15:0]  fifo_push_data;

   logic         loop_on;
   logic         in_load;
   logic         recirc;
   logic         host_push;
   logic         drop;
   logic         play_end;
   logic         gap_end;
   logic         more_after_pop;
   logic [7:0]   head_tune;
   logic [7:0]   head_dur;

   logic [7:0]   tune_d;
   logic         pwm_en_d;
   logic         busy_d;
   logic         done_d;

`ifdef BUZZER_LOOP_EN
   assign loop_on = loop_mode;
`else
   assign loop_on = 1'b0;
`endif

   assign head_tune = fifo_head[TUNE_MSB:TUNE_LSB];
   assign head_dur  = fifo_head[DUR_MSB:DUR_LSB];
   assign in_load   = (state_q == ST_LOAD);

   // A recirculating LOAD owns the FIFO write port; host writes then lose.
   assign recirc         = in_load && loop_on;
   assign host_push      = wr_en && !full && !recirc;
   assign drop           = wr_en && (full || recirc);
   assign fifo_pop       = in_load;
   assign fifo_push      = host_push || recirc;
   assign fifo_push_data = recirc ? fifo_head : wr_data;

   // Terminal counts compared with == so dur=255 at maximum BEAT_DIV never overflows.
   assign play_end = (state_q == ST_PLAY) && (pre_cnt == BEAT_LAST) &&
                     (beat_cnt == dur_lat - 8'd1);
   assign gap_end  = (state_q == ST_GAP) && (gap_cnt == GAP_LAST);

   assign more_after_pop = (fifo_level > LW'(1)) || host_push || recirc;

   buzzer_note_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (16)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (fifo_push_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   assign level = fifo_level;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      finish_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && !fifo_empty) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (head_dur == 8'd0) begin
               if (more_after_pop) state_d = ST_LOAD;
               else begin
                  state_d  = ST_IDLE;
                  finish_d = 1'b1;
               end
            end else begin
               state_d = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (play_end) begin
               if (GAP_CYCLES != 0)  state_d = ST_GAP;
               else if (!fifo_empty) state_d = ST_LOAD;
               else begin
                  state_d  = ST_IDLE;
                  finish_d = 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (gap_end) begin
               if (!fifo_empty) state_d = ST_LOAD;
               else begin
                  state_d  = ST_IDLE;
                  finish_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (stop) begin
         state_d  = ST_IDLE;
         finish_d = 1'b0;
      end
   end

   // Note latch, prescaler, beat and gap counters
   always_ff @(posedge clk) begin
      if (rst) begin
         tune_lat <= TUNE_REST;
         dur_lat  <= '0;
         pre_cnt  <= '0;
         beat_cnt <= '0;
         gap_cnt  <= '0;
      end else begin
         if (in_load) begin
            tune_lat <= head_tune;
            dur_lat  <= head_dur;
            pre_cnt  <= '0;
            beat_cnt <= '0;
         end else if (state_q == ST_PLAY) begin
            if (pre_cnt == BEAT_LAST) begin
               pre_cnt  <= '0;
               beat_cnt <= beat_cnt + 8'd1;
            end else begin
               pre_cnt <= pre_cnt + 24'd1;
            end
         end
         if (state_q == ST_GAP) gap_cnt <= gap_cnt + 24'd1;
         else                   gap_cnt <= '0;
      end
   end

   // Output logic; outputs follow the current state one cycle later,
   // except stop, which silences on the same edge that returns to IDLE.
   always_comb begin
      tune_d   = tune_lat;
      pwm_en_d = (state_q == ST_PLAY) && is_audible(tune_lat) && !stop;
      busy_d   = (state_d != ST_IDLE);
      done_d   = finish_d && !loop_on;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tune   <= '0;
         pwm_en <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         tune   <= tune_d;
         pwm_en <= pwm_en_d;
         busy   <= busy_d;
         done   <= done_d;
      end
   end

   // Sticky dropped-write flag; a drop in the same cycle as start wins.
   always_ff @(posedge clk) begin
      if (rst)                                         overflow <= 1'b0;
      else if (drop)                                   overflow <= 1'b1;
      else if (start && !stop && state_q == ST_IDLE)   overflow <= 1'b0;
   end

endmodule

// File: tb/tb_buzzer_sequencer.sv
// tb_buzzer_sequencer: scoreboard bench for buzzer_sequencer with
// DEPTH=4, BEAT_DIV=4, GAP_CYCLES=2. Stimulus pushes expected audible notes
// {tune, pwm_en high cycles} and expected done pulses; a monitor on the
// falling clock edge measures each pwm_en burst and each done pulse and
// checks them against the queue. Define BUZZER_LOOP_EN to include the loop test.
module tb_buzzer_sequencer;

   typedef struct {
      logic [7:0] tune;
      int         len;
   } note_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [15:0] wr_data = '0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [7:0]  tune;
   logic        pwm_en;
   logic        busy;
   logic        done;
   logic        full;
   logic [2:0]  level;
   logic        overflow;
`ifdef BUZZER_LOOP_EN
   logic        loop_mode = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   note_t exp_notes[$];
   int    exp_dones = 0;

   logic       in_note = 1'b0;
   logic [7:0] cur_tune = '0;
   int         cur_len = 0;

   always #5 clk = ~clk;

   buzzer_sequencer #(
      .DEPTH      (4),
      .BEAT_DIV   (4),
      .GAP_CYCLES (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .start     (start),
      .stop      (stop),
      .tune      (tune),
      .pwm_en    (pwm_en),
      .busy      (busy),
      .done      (done),
      .full      (full),
      .level     (level),
      .overflow  (overflow)
`ifdef BUZZER_LOOP_EN
      ,.loop_mode (loop_mode)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: one comparison set per completed pwm_en burst and per done pulse.
   always @(negedge clk) begin
      if (pwm_en) begin
         if (!in_note) begin
            in_note  = 1'b1;
            cur_tune = tune;
            cur_len  = 1;
         end else begin
            cur_len++;
         end
      end else if (in_note) begin
         in_note = 1'b0;
         if (exp_notes.size() == 0) begin
            total++;
            bad++;
            $display("FAIL note_unexpected: got tune %0h len %0d expected none at %0t",
                     cur_tune, cur_len, $time);
         end else begin
            note_t n;
            n = exp_notes.pop_front();
            chk("note_tune", 32'(cur_tune), 32'(n.tune));
            chk("note_len", 32'(cur_len), 32'(n.len));
         end
      end
      if (done) begin
         total++;
         if (exp_dones > 0) exp_dones--;
         else begin
            bad++;
            $display("FAIL done_unexpected: got done=1 expected done=0 at %0t", $time);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input logic [15:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic expect_note(input logic [7:0] t, input int len);
      note_t n;
      n.tune = t;
      n.len  = len;
      exp_notes.push_back(n);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Cycles from the start edge until done is seen, bounded.
   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done && cyc < 200) begin
         tick();
         cyc++;
      end
   endtask

   task automatic wait_pwm(input string name);
      int n;
      n = 0;
      while (!pwm_en && n < 20) begin
         tick();
         n++;
      end
      chk(name, 32'(pwm_en), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish by 500000");
      $fatal(1);
   end

   initial begin
      int cyc;

      // Reset state
      repeat (3) tick();
      chk("rst_tune", 32'(tune), 32'h0);
      chk("rst_pwm", 32'(pwm_en), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_full", 32'(full), 32'h0);
      chk("rst_level", 32'(level), 32'h0);
      chk("rst_ovf", 32'(overflow), 32'h0);
      rst = 1'b0;
      tick();

      // 1: tone then rest; LOAD(1)+PLAY(12)+GAP(2)+LOAD(1)+PLAY(4)+GAP(2)
      write(16'h1103);
      write(16'h0001);
      chk("t1_level", 32'(level), 32'd2);
      expect_note(8'h11, 12);
      exp_dones++;
      pulse_start();
      chk("t1_busy_after_start", 32'(busy), 32'd1);
      wait_done(cyc);
      chk("t1_done_cycle", 32'(cyc), 32'd22);
      chk("t1_busy_at_done", 32'(busy), 32'd0);
      chk("t1_tune_hold", 32'(tune), 32'h00);
      tick();
      chk("t1_done_single", 32'(done), 32'd0);

      // 2: overflow, fifth entry dropped, start clears overflow
      write(16'h3101);
      write(16'h3201);
      write(16'h3301);
      write(16'h3401);
      chk("t2_ovf_before", 32'(overflow), 32'd0);
      write(16'h3501);
      chk("t2_level", 32'(level), 32'd4);
      chk("t2_full", 32'(full), 32'd1);
      chk("t2_ovf", 32'(overflow), 32'd1);
      expect_note(8'h31, 4);
      expect_note(8'h32, 4);
      expect_note(8'h33, 4);
      expect_note(8'h34, 4);
      exp_dones++;
      pulse_start();
      chk("t2_ovf_cleared", 32'(overflow), 32'd0);
      wait_done(cyc);
      chk("t2_done_cycle", 32'(cyc), 32'd28);
      chk("t2_level_end", 32'(level), 32'd0);
      tick();

      // 3: stop five cycles into a 3-beat note, remaining entries kept
      write(16'h1303);
      write(16'h1401);
      write(16'h1501);
      expect_note(8'h13, 5);
      pulse_start();
      wait_pwm("t3_pwm_rise");
      repeat (4) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("t3_pwm_off", 32'(pwm_en), 32'd0);
      chk("t3_busy_off", 32'(busy), 32'd0);
      chk("t3_no_done", 32'(done), 32'd0);
      chk("t3_level_kept", 32'(level), 32'd2);
      repeat (3) tick();
      expect_note(8'h14, 4);
      expect_note(8'h15, 4);
      exp_dones++;
      pulse_start();
      wait_done(cyc);
      chk("t3_resume_done_cycle", 32'(cyc), 32'd14);
      tick();

      // 4: zero-beat entry skipped
      write(16'h2100);
      write(16'h2201);
      expect_note(8'h22, 4);
      exp_dones++;
      pulse_start();
      wait_done(cyc);
      chk("t4_done_cycle", 32'(cyc), 32'd8);
      chk("t4_tune", 32'(tune), 32'h22);
      tick();

      // start with an empty FIFO is ignored
      pulse_start();
      chk("empty_start_busy", 32'(busy), 32'd0);
      tick();
      chk("empty_start_busy2", 32'(busy), 32'd0);

`ifdef BUZZER_LOOP_EN
      // 5: loop mode repeats the melody until stop
      loop_mode = 1'b1;
      write(16'h2301);
      write(16'h2401);
      for (int r = 0; r < 3; r++) begin
         expect_note(8'h23, 4);
         expect_note(8'h24, 4);
      end
      pulse_start();
      cyc = 0;
      while (exp_notes.size() != 0 && cyc < 200) begin
         tick();
         cyc++;
      end
      chk("t5_notes_consumed", 32'(exp_notes.size()), 32'd0);
      chk("t5_level_loop", 32'(level), 32'd2);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("t5_busy_off", 32'(busy), 32'd0);
      chk("t5_level_after", 32'(level), 32'd2);
      loop_mode = 1'b0;
      repeat (6) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
`endif

      // 6: reset mid-PLAY with overflow set
      write(16'h1601);
      write(16'h1701);
      write(16'h1801);
      write(16'h1901);
      expect_note(8'h16, 3);
      pulse_start();
      wait_pwm("t6_pwm_rise");
      write(16'hA001);
      write(16'hA101);
      chk("t6_ovf_set", 32'(overflow), 32'd1);
      chk("t6_full", 32'(full), 32'd1);
      rst = 1'b1;
      tick();
      chk("t6_tune", 32'(tune), 32'h0);
      chk("t6_pwm", 32'(pwm_en), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_level", 32'(level), 32'd0);
      chk("t6_ovf", 32'(overflow), 32'd0);
      rst = 1'b0;
      repeat (4) tick();

      chk("end_notes_pending", 32'(exp_notes.size()), 32'd0);
      chk("end_dones_pending", 32'(exp_dones), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
